// File: rtl/nibble_deserializer.sv
// Framed serial-to-parallel front end: start/data/parity/stop framing into a
// 4-bit word delivered over a valid/ready slot to the nibble register bank.
module nibble_deserializer #(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       sin_en,
  output logic [3:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [3:0] shreg;
  logic       par_bit;
  logic       slot_free;

  // Even parity: data and parity XOR to zero; always passes without a parity bit.
  function automatic logic parity_ok(input logic [3:0] d, input logic p);
    return PARITY_EN ? ~(^{d, p}) : 1'b1;
  endfunction

  function automatic logic [1:0] bit_pos(input logic [1:0] k);
    return MSB_FIRST ? ~k : k;
  endfunction

  // A stop-edge load may reuse the slot when the old nibble leaves on the same edge.
  assign slot_free = !q_valid || q_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      shreg      <= 4'b0000;
      par_bit    <= 1'b0;
      q          <= 4'b0000;
      q_valid    <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (q_valid && q_ready)
        q_valid <= 1'b0;

      if (sin_en) begin
        case (state)
          S_IDLE: begin
            if (!sin) begin
              state <= S_DATA;
              cnt   <= 2'd0;
              busy  <= 1'b1;
            end
          end
          S_DATA: begin
            shreg[bit_pos(cnt)] <= sin;
            cnt                 <= cnt + 2'd1;
            if (cnt == 2'd3)
              state <= PARITY_EN ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            par_bit <= sin;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (!sin)
              frame_err <= 1'b1;
            else if (!parity_ok(shreg, par_bit))
              parity_err <= 1'b1;
            else if (slot_free) begin
              q       <= shreg;
              q_valid <= 1'b1;
            end else
              overrun <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/nibble_deserializer.md
# nibble_deserializer

- Serial-to-parallel front end that assembles framed serial bits into 4-bit words.
- Delivers each word over a valid/ready handshake to the downstream 4-bit register stage, whose `d` input it drives.
- Frames are checked for start, parity and stop, and bad frames are dropped with one-cycle error pulses.
- Sits between the serial input pin logic and the nibble register bank.

## Interface

**Parameters**
- `MSB_FIRST`, default 0: 0 = data bits arrive LSB first; 1 = MSB first.
- `PARITY_EN`, default 1: 1 = frame carries an even-parity bit after the data; 0 = no parity bit.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `sin`, input, 1: serial data line, sampled only when `sin_en`=1.
- `sin_en`, input, 1: bit strobe; one serial bit per cycle in which it is high.
- `q`, output, 4: assembled nibble; feeds the downstream register `d`.
- `q_valid`, output, 1: `q` holds an unconsumed nibble.
- `q_ready`, input, 1: downstream accepts `q` this cycle.
- `busy`, output, 1: a frame is in progress (state is not IDLE).
- `parity_err`, output, 1: one-cycle pulse when a frame is dropped for bad parity.
- `frame_err`, output, 1: one-cycle pulse when a frame is dropped for a bad stop bit.
- `overrun`, output, 1: one-cycle pulse when a good frame is dropped because the output slot is full.

## Operation

**Frame format (in strobe order)**
- Start bit = 0.
- 4 data bits.
- Parity bit, only if `PARITY_EN`=1; even parity, so XOR of data and parity = 0.
- Stop bit = 1.

**States:** IDLE, DATA, PARITY, STOP.

**IDLE**
- On strobe with `sin`=0, go to DATA and clear the bit counter.
- On strobe with `sin`=1, stay in IDLE; this is line idle, not an error.

**DATA**
- Each strobe shifts `sin` into the shift register and increments a 2-bit counter.
- With `MSB_FIRST`=0, bit k lands in position k (LSB first).
- With `MSB_FIRST`=1, the first bit lands in position 3.
- After the 4th data bit, go to PARITY if `PARITY_EN`=1, else to STOP.

**PARITY**
- One strobe stores the parity bit, then go to STOP.

**STOP**
- On strobe, always return to IDLE. The frame outcome is decided on this same edge, in priority order:
  1. `sin`=0: pulse `frame_err`; drop the frame.
  2. Else, parity mismatch (only when `PARITY_EN`=1): pulse `parity_err`; drop the frame.
  3. Else, output slot free (`q_valid`=0, or `q_valid`=1 and `q_ready`=1 this cycle): load `q` and set `q_valid`=1.
  4. Else: pulse `overrun`; drop the new nibble; the old `q` is kept.
- At most one error pulse fires per frame.

**Output slot**
- `q_valid` clears on an edge where `q_valid`=1 and `q_ready`=1, unless a new nibble loads on that same edge.
- `q` is stable while `q_valid`=1 and is not cleared on consume; it holds the last value.
- `q_ready` while `q_valid`=0 has no effect.

**Strobe handling**
- Cycles with `sin_en`=0 hold all frame state, with unbounded gaps between strobes.
- The output handshake keeps running independently of strobes.

## Timing

**Reset (asynchronous)**
- `rst` high forces, immediately: state IDLE, counter 0, shift register 0, `q`=4'b0000, `q_valid`=0, `busy`=0, `parity_err`=0, `frame_err`=0, `overrun`=0.
- Reset mid-frame discards the partial frame and emits no error pulse.
- After `rst` falls, the first strobe with `sin`=0 is a start bit.

**Latency**
- `q`/`q_valid` update on the same rising edge that samples the stop bit.
- They are visible immediately after that edge, 0 extra cycles.

**Pulses and busy**
- Error pulses are registered: high for exactly the one cycle following the stop-bit edge.
- `busy` is 1 from the edge that samples the start bit through the edge that samples the stop bit.

**Back-to-back**
- A new start bit may be strobed in the cycle immediately after the stop bit.
- Throughput is one nibble per 7 strobes with parity, 6 without.

**Simultaneous events**
- Stop-bit load and consume of the old nibble on the same edge: the new nibble replaces it and `q_valid` stays 1.

## Test plan

1. **Reset:** assert `rst` mid-frame (after 2 data bits), release, then send a clean frame 4'b1010.
   - During reset: all outputs 0.
   - After reset: `q`=4'b1010 with `q_valid`=1 and no error pulses.
2. **Basic frames, `PARITY_EN`=1, `MSB_FIRST`=0:** send 4'b0001, 4'b1010, 4'b1111, 4'b0101 with `q_ready`=1, strobes every cycle and every 3rd cycle.
   - Each nibble appears on `q` at its stop edge, in order.
   - Each is consumed within one cycle.
3. **Errors:**
   - Frame 4'b1001 with parity bit 1 -> `parity_err` one-cycle pulse; `q`/`q_valid` unchanged.
   - Frame 4'b0110 with stop bit 0 -> `frame_err` pulse only, even if parity is also wrong.
4. **Backpressure:** hold `q_ready`=0 and send 4'b0011 then 4'b1100.
   - `q`=4'b0011 stays valid; `overrun` pulses at the second stop edge.
   - Raising `q_ready` for one cycle then clears `q_valid`.
5. **Simultaneous load/consume:** with `q`=4'b0111 valid, assert `q_ready` exactly on the stop edge of frame 4'b1000.
   - `q`=4'b1000, `q_valid` stays 1, no `overrun`.
6. **Parameters:** with `MSB_FIRST`=1, `PARITY_EN`=0, send bits 1,0,0,1 then stop 1.
   - `q`=4'b1001 after 6 strobes.
   - Idle strobes with `sin`=1 in IDLE leave `busy`=0.
